// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  // Arbiter FSM encoding: only IDLE may grant a new access.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_t;

  // Side that received the most recent grant (round-robin memory).
  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_side_t;

  // Default number of BUSY cycles waited for MemAck before giving up.
  localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/mem_arbiter_timer.sv
// Wait counter for an outstanding memory access. Cleared on grant and
// advanced on every BUSY cycle that has no MemAck. o_expired flags the
// BUSY cycle whose increment would bring the count to TIMEOUT, so a
// MemAck in that same cycle (which disables the increment) still wins.
module arb_timer
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  logic [7:0] r_count;

  // Wait counter: clear on grant, count BUSY cycles without acknowledge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= 8'd0;
    end else if (i_clear) begin
      r_count <= 8'd0;
    end else if (i_enable) begin
      r_count <= r_count + 8'd1;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_expired = i_enable & (r_count == LAST_COUNT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported unified memory between the fetch
// stage (I side) and the memory stage (D side). Round-robin on ties,
// registered memory interface, one-cycle Ready pulses, sticky timeout.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int addWidth  = 6,
  parameter int dataWidth = 32,
  parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 IReq,
  input  logic [addWidth-1:0]  IAdr,
  output logic [dataWidth-1:0] IRdata,
  output logic                 IReady,
  input  logic                 DReq,
  input  logic                 DWe,
  input  logic [addWidth-1:0]  DAdr,
  input  logic [dataWidth-1:0] DWdata,
  output logic [dataWidth-1:0] DRdata,
  output logic                 DReady,
  output logic                 MemReq,
  output logic                 MemWe,
  output logic [addWidth-1:0]  MemAdr,
  output logic [dataWidth-1:0] MemWdata,
  input  logic [dataWidth-1:0] MemRdata,
  input  logic                 MemAck,
  output logic                 StallFetch,
  output logic                 StallMem,
  output logic                 MemErr
);

  arb_state_t            r_state;
  arb_state_t            w_state_next;
  grant_side_t           r_last_grant;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [addWidth-1:0]   r_mem_adr;
  logic [dataWidth-1:0]  r_mem_wdata;
  logic [dataWidth-1:0]  r_i_rdata;
  logic [dataWidth-1:0]  r_d_rdata;
  logic                  r_i_ready;
  logic                  r_d_ready;
  logic                  r_mem_err;

  logic w_busy;
  logic w_timer_en;
  logic w_expired;
  logic w_i_eligible;
  logic w_d_eligible;
  logic w_grant_i;
  logic w_grant_d;
  logic w_finish;
  logic w_timeout;

  // A requester whose Ready pulses this cycle is still holding Req for
  // the access just completed, so it must not be granted again.
  assign w_i_eligible = IReq & ~r_i_ready;
  assign w_d_eligible = DReq & ~r_d_ready;

  assign w_busy     = (r_state == ST_BUSY_I) | (r_state == ST_BUSY_D);
  assign w_timer_en = w_busy & ~MemAck;
  assign w_timeout  = w_finish & ~MemAck;

  arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_clear   (w_grant_i | w_grant_d),
    .i_enable  (w_timer_en),
    .o_expired (w_expired)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: arbitration in IDLE, completion or timeout in BUSY.
  always_comb begin
    w_state_next = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_i_eligible && w_d_eligible) begin
          if (r_last_grant == GNT_I) begin
            w_grant_d = 1'b1;
          end else begin
            w_grant_i = 1'b1;
          end
        end else if (w_i_eligible) begin
          w_grant_i = 1'b1;
        end else if (w_d_eligible) begin
          w_grant_d = 1'b1;
        end else begin
          w_grant_i = 1'b0;
        end
        if (w_grant_i) begin
          w_state_next = ST_BUSY_I;
        end else if (w_grant_d) begin
          w_state_next = ST_BUSY_D;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (MemAck || w_expired) begin
          w_finish     = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = r_state;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Memory-side registers, read-data capture, Ready pulses and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= GNT_I;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_adr    <= '0;
      r_mem_wdata  <= '0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
      r_i_ready    <= 1'b0;
      r_d_ready    <= 1'b0;
      r_mem_err    <= 1'b0;
    end else begin
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      if (w_grant_i) begin
        r_mem_req    <= 1'b1;
        r_mem_we     <= 1'b0;
        r_mem_adr    <= IAdr;
        r_last_grant <= GNT_I;
      end else if (w_grant_d) begin
        r_mem_req    <= 1'b1;
        r_mem_we     <= DWe;
        r_mem_adr    <= DAdr;
        r_mem_wdata  <= DWdata;
        r_last_grant <= GNT_D;
      end else if (w_finish) begin
        r_mem_req <= 1'b0;
        if (r_state == ST_BUSY_I) begin
          r_i_ready <= 1'b1;
          r_i_rdata <= MemAck ? MemRdata : '0;
        end else begin
          r_d_ready <= 1'b1;
          if (!r_mem_we) begin
            r_d_rdata <= MemAck ? MemRdata : '0;
          end else begin
            r_d_rdata <= r_d_rdata;
          end
        end
        if (w_timeout) begin
          r_mem_err <= 1'b1;
        end else begin
          r_mem_err <= r_mem_err;
        end
      end else begin
        r_mem_req <= r_mem_req;
      end
    end
  end

  assign IRdata     = r_i_rdata;
  assign IReady     = r_i_ready;
  assign DRdata     = r_d_rdata;
  assign DReady     = r_d_ready;
  assign MemReq     = r_mem_req;
  assign MemWe      = r_mem_we;
  assign MemAdr     = r_mem_adr;
  assign MemWdata   = r_mem_wdata;
  assign MemErr     = r_mem_err;
  assign StallFetch = IReq & ~r_i_ready;
  assign StallMem   = DReq & ~r_d_ready;

endmodule
